// File: rtl/async_fifo_gray.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo_gray
// Purpose  : Dual-clock FIFO; only registered Gray pointers cross the domains.
// Revision : 1.0 - initial release
// ============================================================================
module async_fifo_gray #(
   parameter int D_SIZE      = 8,
   parameter int A_SIZE      = 3,
   parameter int SYNC_STAGES = 2,
   parameter int AFULL_TH    = 6,
   parameter int AEMPTY_TH   = 2
) (
   input  logic              i_w_clk,
   input  logic              i_w_rstn,
   input  logic              i_r_clk,
   input  logic              i_r_rstn,
   input  logic              i_w_inc,
   input  logic [D_SIZE-1:0] i_w_data,
   output logic              o_full,
   output logic              o_afull,
   output logic [A_SIZE:0]   o_w_level,
   output logic              o_w_overflow,
   input  logic              i_r_inc,
   output logic [D_SIZE-1:0] o_r_data,
   output logic              o_empty,
   output logic              o_aempty,
   output logic [A_SIZE:0]   o_r_level,
   output logic              o_r_underflow
);

   localparam int              c_depth     = 1 << A_SIZE;
   localparam logic [A_SIZE:0] c_afull_th  = (A_SIZE+1)'(AFULL_TH);
   localparam logic [A_SIZE:0] c_aempty_th = (A_SIZE+1)'(AEMPTY_TH);

   function automatic logic [A_SIZE:0] gray2bin(input logic [A_SIZE:0] g);
      logic [A_SIZE:0] b;
      b[A_SIZE] = g[A_SIZE];
      for (int i = A_SIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [D_SIZE-1:0] mem [c_depth];

   // ---------------- write domain ----------------
   logic [A_SIZE:0] wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d;
   logic [A_SIZE:0] wr_level_q, wr_level_d;
   logic [A_SIZE:0] rsync_q [SYNC_STAGES];
   logic [A_SIZE:0] rd_gray_sync, rd_bin_sync;
   logic            wr_full_q, wr_full_d, wr_afull_q, wr_afull_d, wr_ovf_q;
   logic            wr_push;

   // Read pointer register is declared here because the write-side chain samples it.
   logic [A_SIZE:0] rd_bin_q, rd_bin_d, rd_gray_q, rd_gray_d;

   assign wr_push      = i_w_inc & ~wr_full_q;
   assign wr_bin_d     = wr_bin_q + (A_SIZE+1)'(wr_push);
   assign wr_gray_d    = wr_bin_d ^ (wr_bin_d >> 1);
   assign rd_gray_sync = rsync_q[SYNC_STAGES-1];
   assign rd_bin_sync  = gray2bin(rd_gray_sync);
   // Full when the next write pointer is exactly one lap ahead of the synced read pointer.
   assign wr_full_d    = (wr_gray_d == {~rd_gray_sync[A_SIZE:A_SIZE-1], rd_gray_sync[A_SIZE-2:0]});
   assign wr_level_d   = wr_bin_d - rd_bin_sync;
   assign wr_afull_d   = (wr_level_d >= c_afull_th);

   always_ff @(posedge i_w_clk or negedge i_w_rstn) begin
      if (!i_w_rstn) begin
         wr_bin_q   <= '0;
         wr_gray_q  <= '0;
         wr_level_q <= '0;
         wr_full_q  <= 1'b0;
         wr_afull_q <= 1'b0;
         wr_ovf_q   <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) rsync_q[i] <= '0;
      end else begin
         wr_bin_q   <= wr_bin_d;
         wr_gray_q  <= wr_gray_d;
         wr_level_q <= wr_level_d;
         wr_full_q  <= wr_full_d;
         wr_afull_q <= wr_afull_d;
         if (i_w_inc && wr_full_q) wr_ovf_q <= 1'b1;
         rsync_q[0] <= rd_gray_q;
         for (int i = 1; i < SYNC_STAGES; i++) rsync_q[i] <= rsync_q[i-1];
      end
   end

   always_ff @(posedge i_w_clk) begin
      if (wr_push) mem[wr_bin_q[A_SIZE-1:0]] <= i_w_data;
   end

   // ---------------- read domain ----------------
   logic [A_SIZE:0] rd_level_q, rd_level_d;
   logic [A_SIZE:0] wsync_q [SYNC_STAGES];
   logic [A_SIZE:0] wr_gray_sync, wr_bin_sync;
   logic            rd_empty_q, rd_empty_d, rd_aempty_q, rd_aempty_d, rd_udf_q;
   logic            rd_pop;

   assign rd_pop       = i_r_inc & ~rd_empty_q;
   assign rd_bin_d     = rd_bin_q + (A_SIZE+1)'(rd_pop);
   assign rd_gray_d    = rd_bin_d ^ (rd_bin_d >> 1);
   assign wr_gray_sync = wsync_q[SYNC_STAGES-1];
   assign wr_bin_sync  = gray2bin(wr_gray_sync);
   assign rd_empty_d   = (rd_gray_d == wr_gray_sync);
   assign rd_level_d   = wr_bin_sync - rd_bin_d;
   assign rd_aempty_d  = (rd_level_d <= c_aempty_th);

   always_ff @(posedge i_r_clk or negedge i_r_rstn) begin
      if (!i_r_rstn) begin
         rd_bin_q    <= '0;
         rd_gray_q   <= '0;
         rd_level_q  <= '0;
         rd_empty_q  <= 1'b1;
         rd_aempty_q <= 1'b1;
         rd_udf_q    <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) wsync_q[i] <= '0;
      end else begin
         rd_bin_q    <= rd_bin_d;
         rd_gray_q   <= rd_gray_d;
         rd_level_q  <= rd_level_d;
         rd_empty_q  <= rd_empty_d;
         rd_aempty_q <= rd_aempty_d;
         if (i_r_inc && rd_empty_q) rd_udf_q <= 1'b1;
         wsync_q[0] <= wr_gray_q;
         for (int i = 1; i < SYNC_STAGES; i++) wsync_q[i] <= wsync_q[i-1];
      end
   end

   assign o_r_data      = mem[rd_bin_q[A_SIZE-1:0]];
   assign o_full        = wr_full_q;
   assign o_afull       = wr_afull_q;
   assign o_w_level     = wr_level_q;
   assign o_w_overflow  = wr_ovf_q;
   assign o_empty       = rd_empty_q;
   assign o_aempty      = rd_aempty_q;
   assign o_r_level     = rd_level_q;
   assign o_r_underflow = rd_udf_q;

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_gray.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_async_fifo_gray
// Purpose  : Directed and queue-checked traffic bench for async_fifo_gray.
// Revision : 1.0 - initial release
// ============================================================================
module tb_async_fifo_gray;

   logic       w_clk = 1'b0, r_clk = 1'b0;
   logic       w_rstn = 1'b0, r_rstn = 1'b0;
   logic       w_inc = 1'b0, r_inc = 1'b0;
   logic [7:0] w_data = '0;
   logic       full, afull, w_ovf, empty, aempty, r_udf;
   logic [3:0] w_level, r_level;
   logic [7:0] r_data;

   int w_half = 5;
   int r_half = 13;
   int checks = 0;
   int errors = 0;

   always #(w_half) w_clk = ~w_clk;
   always #(r_half) r_clk = ~r_clk;

   async_fifo_gray dut (
      .i_w_clk(w_clk), .i_w_rstn(w_rstn), .i_r_clk(r_clk), .i_r_rstn(r_rstn),
      .i_w_inc(w_inc), .i_w_data(w_data),
      .o_full(full), .o_afull(afull), .o_w_level(w_level), .o_w_overflow(w_ovf),
      .i_r_inc(r_inc), .o_r_data(r_data),
      .o_empty(empty), .o_aempty(aempty), .o_r_level(r_level), .o_r_underflow(r_udf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] d);
      @(negedge w_clk); w_inc = 1'b1; w_data = d;
      @(negedge w_clk); w_inc = 1'b0;
   endtask

   task automatic rd();
      @(negedge r_clk); r_inc = 1'b1;
      @(negedge r_clk); r_inc = 1'b0;
   endtask

   task automatic do_reset();
      w_rstn = 1'b0; r_rstn = 1'b0;
      repeat (4) @(negedge r_clk);
      @(negedge w_clk); w_rstn = 1'b1;
      @(negedge r_clk); r_rstn = 1'b1;
      repeat (2) @(negedge r_clk);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_empty"},  empty,   1);
      chk({tag, "_aempty"}, aempty,  1);
      chk({tag, "_full"},   full,    0);
      chk({tag, "_afull"},  afull,   0);
      chk({tag, "_wlevel"}, w_level, 0);
      chk({tag, "_rlevel"}, r_level, 0);
      chk({tag, "_ovf"},    w_ovf,   0);
      chk({tag, "_udf"},    r_udf,   0);
   endtask

   task automatic traffic(input int n, input string tag);
      logic [7:0] q[$];
      int  wsent = 0, rgot = 0, wcyc = 0, rcyc = 0;
      logic lvl_bad = 1'b0;
      fork
         begin
            while (wsent < n && wcyc < 6000) begin
               @(negedge w_clk); wcyc++;
               if (w_level > 4'd8) lvl_bad = 1'b1;
               if (!full && $urandom_range(0, 3) != 0) begin
                  w_data = 8'($urandom);
                  w_inc  = 1'b1;
                  q.push_back(w_data);
                  wsent++;
               end else w_inc = 1'b0;
            end
            @(negedge w_clk); w_inc = 1'b0;
         end
         begin
            while (rgot < n && rcyc < 6000) begin
               @(negedge r_clk); rcyc++;
               if (r_level > 4'd8) lvl_bad = 1'b1;
               if (!empty && q.size() == 0) begin
                  chk({tag, "_spurious"}, empty, 1);
                  r_inc = 1'b0;
               end else if (!empty && $urandom_range(0, 2) != 0) begin
                  chk({tag, "_data"}, r_data, q[0]);
                  void'(q.pop_front());
                  r_inc = 1'b1;
                  rgot++;
               end else r_inc = 1'b0;
            end
            @(negedge r_clk); r_inc = 1'b0;
         end
      join
      chk({tag, "_count"}, rgot, n);
      chk({tag, "_lvlmax"}, lvl_bad, 0);
      repeat (5) @(negedge r_clk);
      chk({tag, "_ovf"}, w_ovf, 0);
      chk({tag, "_udf"}, r_udf, 0);
      chk({tag, "_end_empty"}, empty, 1);
   endtask

   initial begin
      int n;
      // 1. reset
      do_reset();
      chk_reset_state("rst");

      // 2. fill: afull from the 6th word, full on the 8th, then overflow
      for (int i = 1; i <= 8; i++) begin
         wr(8'h10 + 8'(i - 1));
         chk("fill_level", w_level, i);
         chk("fill_afull", afull, (i >= 6));
         chk("fill_full",  full,  (i == 8));
      end
      wr(8'hEE);
      chk("ovf_flag",  w_ovf,   1);
      chk("ovf_level", w_level, 8);
      chk("ovf_full",  full,    1);

      // 3. drain in order, aempty at level <= 2, then underflow
      repeat (6) @(negedge r_clk);
      chk("drain_rlevel0", r_level, 8);
      chk("drain_empty0",  empty,   0);
      for (int k = 0; k < 8; k++) begin
         @(negedge r_clk);
         chk("drain_data",   r_data,  8'h10 + 8'(k));
         chk("drain_level",  r_level, 8 - k);
         chk("drain_aempty", aempty,  ((8 - k) <= 2));
         rd();
      end
      chk("drain_empty",  empty,   1);
      chk("drain_rlevel", r_level, 0);
      chk("drain_udf0",   r_udf,   0);
      rd();
      chk("udf_flag", r_udf, 1);
      repeat (6) @(negedge w_clk);
      chk("free_full",   full,    0);
      chk("free_wlevel", w_level, 0);
      chk("free_afull",  afull,   0);

      // 4. single write latency across the boundary
      wr(8'hA5);
      n = 0;
      while (empty && n < 4) begin
         @(posedge r_clk); #1; n++;
      end
      chk("lat_edges", (n <= 3), 1);
      chk("lat_empty", empty, 0);
      chk("lat_data",  r_data, 8'hA5);
      rd();
      chk("lat_empty_after", empty, 1);

      // 6. reset while half full
      for (int i = 0; i < 4; i++) wr(8'hC0 + 8'(i));
      repeat (6) @(negedge r_clk);
      chk("half_rlevel", r_level, 4);
      do_reset();
      chk_reset_state("midrst");
      wr(8'h5A);
      repeat (6) @(negedge r_clk);
      chk("midrst_data",  r_data, 8'h5A);
      chk("midrst_level", r_level, 1);
      rd();
      chk("midrst_empty", empty, 1);

      // 5. random traffic, fast write / slow read, then swapped
      traffic(300, "fastw");
      w_half = 13; r_half = 5;
      traffic(300, "fastr");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
